pc_src_ctrl: RTL and testbench

- Sequencing FSM that drives the PC-source select code, the PC write enable and the EPC write enable of the multicycle datapath.
- It is the producing end of the PC-source select interface.
- Sits between the main control unit, which issues fetch requests and decoded redirect requests, and the PC source mux / PC / EPC registers.
- Guarantees exactly one PC write per instruction, or none for sequential and not-taken cases beyond the fetch increment, with fixed latencies.

---
 rtl/pc_src_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_pc_src_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_src_ctrl.sv
// ---------------------------------------------------------------------------
// pc_src_ctrl
//
// Sequencing FSM for the PC-source side of the multicycle datapath. For each
// instruction it produces one fetch increment (PC+4 write) after a fixed wait.
// It then produces at most one further PC write: a resolved redirect, or the
// exception vector. An exception is preceded by a single EPC save. All
// outputs are registered, so every pulse is glitch-free and lasts one cycle.
//
// Parameters
//   FETCH_WAIT      cycles spent in FETCH before the PC+4 write (1..15)
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   fetch_req       start of instruction, sampled only in IDLE
//   redirect_valid  decoded redirect request, sampled only in DECODE
//   redirect_kind   0 seq, 1 beq, 2 bne, 3 jump, 4 jr, 5 rte, 6-7 illegal
//   alu_zero        ALU zero flag, captured together with the redirect
//   exc_req         exception request, sampled in FETCH (pended) and DECODE
//   pc_src          PC mux select (000 PC+4, 001 branch, 010 jump,
//                   011 exception vector, 100 register, 101 EPC)
//   pc_write        PC load enable, one-cycle pulse
//   epc_write       EPC load enable, one-cycle pulse
//   busy            high from fetch acceptance through the done pulse
//   done            one-cycle pulse at the end of each instruction
// ---------------------------------------------------------------------------
module pc_src_ctrl #(
  parameter int FETCH_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic       redirect_valid,
  input  logic [2:0] redirect_kind,
  input  logic       alu_zero,
  input  logic       exc_req,
  output logic [2:0] pc_src,
  output logic       pc_write,
  output logic       epc_write,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_RESOLVE  = 3'd3,
    S_EXC_SAVE = 3'd4,
    S_EXC_VEC  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  // The counter is loaded with FETCH_WAIT-1 so that the PC+4 write is issued
  // on the FETCH_WAIT-th edge spent in FETCH.
  localparam logic [3:0] CNT_LOAD = 4'(FETCH_WAIT - 1);

  localparam logic [2:0] SRC_PC4 = 3'b000;
  localparam logic [2:0] SRC_BR  = 3'b001;
  localparam logic [2:0] SRC_JMP = 3'b010;
  localparam logic [2:0] SRC_VEC = 3'b011;
  localparam logic [2:0] SRC_REG = 3'b100;
  localparam logic [2:0] SRC_EPC = 3'b101;

  localparam logic [2:0] K_SEQ  = 3'd0;
  localparam logic [2:0] K_BEQ  = 3'd1;
  localparam logic [2:0] K_BNE  = 3'd2;
  localparam logic [2:0] K_JMP  = 3'd3;
  localparam logic [2:0] K_JR   = 3'd4;
  localparam logic [2:0] K_RTE  = 3'd5;
  localparam logic [2:0] K_ILL0 = 3'd6;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_exc_pend, w_exc_pend_nxt;
  logic [2:0] r_kind, w_kind_nxt;
  logic       r_zero, w_zero_nxt;

  logic [2:0] r_pc_src, w_pc_src_nxt;
  logic       r_pc_write, w_pc_write_nxt;
  logic       r_epc_write, w_epc_write_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;

  // State, counter, pending flag and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_exc_pend  <= 1'b0;
      r_pc_src    <= SRC_PC4;
      r_pc_write  <= 1'b0;
      r_epc_write <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_exc_pend  <= w_exc_pend_nxt;
      r_pc_src    <= w_pc_src_nxt;
      r_pc_write  <= w_pc_write_nxt;
      r_epc_write <= w_epc_write_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Latched redirect operands are pure data; they are only consumed in
  // RESOLVE, which is always entered through a fresh capture in DECODE.
  always_ff @(posedge clk) begin
    r_kind <= w_kind_nxt;
    r_zero <= w_zero_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_exc_pend_nxt  = r_exc_pend;
    w_kind_nxt      = r_kind;
    w_zero_nxt      = r_zero;
    w_pc_src_nxt    = SRC_PC4;
    w_pc_write_nxt  = 1'b0;
    w_epc_write_nxt = 1'b0;
    w_done_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (fetch_req) begin
          w_state_nxt = S_FETCH;
          w_cnt_nxt   = CNT_LOAD;
        end
      end

      S_FETCH: begin
        // An exception raised during fetch is remembered and honoured on the
        // first DECODE cycle; the fetch increment still happens.
        if (exc_req) begin
          w_exc_pend_nxt = 1'b1;
        end
        if (r_cnt == 4'd0) begin
          w_pc_write_nxt = 1'b1;
          w_state_nxt    = S_DECODE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      S_DECODE: begin
        // Exceptions (pending, live, or an illegal redirect kind) take
        // priority over a simultaneous legal redirect.
        if (r_exc_pend || exc_req || (redirect_valid && (redirect_kind >= K_ILL0))) begin
          w_state_nxt = S_EXC_SAVE;
        end else if (redirect_valid) begin
          w_state_nxt = S_RESOLVE;
          w_kind_nxt  = redirect_kind;
          w_zero_nxt  = alu_zero;
        end
      end

      S_RESOLVE: begin
        case (r_kind)
          K_SEQ: begin
            w_pc_write_nxt = 1'b0;
          end
          K_BEQ: begin
            if (r_zero) begin
              w_pc_write_nxt = 1'b1;
              w_pc_src_nxt   = SRC_BR;
            end
          end
          K_BNE: begin
            if (!r_zero) begin
              w_pc_write_nxt = 1'b1;
              w_pc_src_nxt   = SRC_BR;
            end
          end
          K_JMP: begin
            w_pc_write_nxt = 1'b1;
            w_pc_src_nxt   = SRC_JMP;
          end
          K_JR: begin
            w_pc_write_nxt = 1'b1;
            w_pc_src_nxt   = SRC_REG;
          end
          K_RTE: begin
            w_pc_write_nxt = 1'b1;
            w_pc_src_nxt   = SRC_EPC;
          end
          default: begin
            w_pc_write_nxt = 1'b0;
          end
        endcase
        w_state_nxt = S_DONE;
      end

      S_EXC_SAVE: begin
        w_epc_write_nxt = 1'b1;
        w_exc_pend_nxt  = 1'b0;
        w_state_nxt     = S_EXC_VEC;
      end

      S_EXC_VEC: begin
        w_pc_write_nxt = 1'b1;
        w_pc_src_nxt   = SRC_VEC;
        w_state_nxt    = S_DONE;
      end

      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // busy stays up through the cycle that shows the done pulse, so the
    // instruction is covered end to end.
    w_busy_nxt = (w_state_nxt != S_IDLE) || (r_state == S_DONE);
  end

  assign pc_src    = r_pc_src;
  assign pc_write  = r_pc_write;
  assign epc_write = r_epc_write;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_pc_src_ctrl.sv
module tb_pc_src_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_req;
  logic       redirect_valid;
  logic [2:0] redirect_kind;
  logic       alu_zero;
  logic       exc_req;

  logic [2:0] pc_src    [2];
  logic       pc_write  [2];
  logic       epc_write [2];
  logic       busy      [2];
  logic       done      [2];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0 uses FETCH_WAIT=1, instance 1 uses FETCH_WAIT=4; both see the
  // same stimulus.
  pc_src_ctrl #(.FETCH_WAIT(1)) u_fw1 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req),
    .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
    .alu_zero(alu_zero), .exc_req(exc_req),
    .pc_src(pc_src[0]), .pc_write(pc_write[0]), .epc_write(epc_write[0]),
    .busy(busy[0]), .done(done[0])
  );

  pc_src_ctrl #(.FETCH_WAIT(4)) u_fw4 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req),
    .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
    .alu_zero(alu_zero), .exc_req(exc_req),
    .pc_src(pc_src[1]), .pc_write(pc_write[1]), .epc_write(epc_write[1]),
    .busy(busy[1]), .done(done[1])
  );

  typedef struct packed {
    int       cyc;
    logic     pcw;
    logic     epcw;
    logic [2:0] src;
    logic     dn;
    logic     bf;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  function automatic int fw(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic push(input int i, input int c, input logic pcw, input logic epcw,
                      input logic [2:0] src, input logic dn, input logic bf);
    ev_t e;
    e.cyc = c; e.pcw = pcw; e.epcw = epcw; e.src = src; e.dn = dn; e.bf = bf;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_w(input int i, input int c, input logic [2:0] src);
    push(i, c, 1'b1, 1'b0, src, 1'b0, 1'b0);
  endtask

  task automatic push_exc(input int i, input int e);
    push(i, e + 1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
    push_w(i, e + 2, 3'b011);
    push(i, e + 3, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    push(i, e + 4, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
  endtask

  // {take, src} for a legal redirect kind, from the select-code table.
  function automatic logic [3:0] exp_redir(input logic [2:0] kind, input logic z);
    case (kind)
      3'd1:    return z  ? 4'b1001 : 4'b0000;
      3'd2:    return !z ? 4'b1001 : 4'b0000;
      3'd3:    return 4'b1010;
      3'd4:    return 4'b1100;
      3'd5:    return 4'b1101;
      default: return 4'b0000;
    endcase
  endfunction

  // Scoreboard monitor: any visible activity is an event that must match the
  // head of the expected queue for that instance.
  logic prev_busy [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    ev_t a, e;
    int qs;
    for (int i = 0; i < 2; i++) begin
      a.cyc = cyc; a.pcw = pc_write[i]; a.epcw = epc_write[i]; a.src = pc_src[i];
      a.dn = done[i]; a.bf = prev_busy[i] & ~busy[i];
      if (a.pcw || a.epcw || a.dn || a.bf || (a.src != 3'b000)) begin
        qs = (i == 0) ? q0.size() : q1.size();
        n_cmp++;
        if (qs == 0) begin
          n_bad++;
          $display("FAIL unexpected inst%0d got{cyc=%0d pcw=%0b epcw=%0b src=%03b done=%0b bfall=%0b} want{no event}",
                   i, a.cyc, a.pcw, a.epcw, a.src, a.dn, a.bf);
        end else begin
          if (i == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          if (a !== e) begin
            n_bad++;
            $display("FAIL event inst%0d got{cyc=%0d pcw=%0b epcw=%0b src=%03b done=%0b bfall=%0b} want{cyc=%0d pcw=%0b epcw=%0b src=%03b done=%0b bfall=%0b}",
                     i, a.cyc, a.pcw, a.epcw, a.src, a.dn, a.bf,
                     e.cyc, e.pcw, e.epcw, e.src, e.dn, e.bf);
          end
        end
      end
      prev_busy[i] = busy[i];
    end
  end

  task automatic chk_zero(input string nm);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({pc_write[i], epc_write[i], pc_src[i], busy[i], done[i]} !== 7'b0) begin
        n_bad++;
        $display("FAIL %s inst%0d got pcw=%0b epcw=%0b src=%03b busy=%0b done=%0b want all 0",
                 nm, i, pc_write[i], epc_write[i], pc_src[i], busy[i], done[i]);
      end
    end
  endtask

  task automatic clear_inputs();
    fetch_req = 1'b0; redirect_valid = 1'b0; redirect_kind = 3'd0;
    alu_zero = 1'b0; exc_req = 1'b0;
  endtask

  // One instruction: fetch at edge k, decode stimulus at edge m = k+6 (both
  // instances are in DECODE by then), or an exception pulsed during FETCH.
  task automatic instr(input logic [2:0] kind, input logic zero, input logic valid,
                       input logic exc_dec, input logic exc_fetch);
    int k, m;
    logic [3:0] r;
    @(negedge clk);
    fetch_req = 1'b1;
    k = cyc + 1;
    m = k + 6;
    r = exp_redir(kind, zero);
    for (int i = 0; i < 2; i++) begin
      push_w(i, k + fw(i), 3'b000);
      if (exc_fetch) begin
        push_exc(i, k + fw(i) + 1);
      end else if (exc_dec || (valid && kind >= 3'd6)) begin
        push_exc(i, m);
      end else begin
        if (r[3]) push_w(i, m + 1, r[2:0]);
        push(i, m + 2, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
        push(i, m + 3, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
      end
    end
    @(negedge clk);
    fetch_req = 1'b0;
    exc_req = exc_fetch;
    @(negedge clk);
    exc_req = 1'b0;
    if (!exc_fetch) begin
      while (cyc < m - 1) @(negedge clk);
      redirect_valid = valid; redirect_kind = kind; alu_zero = zero; exc_req = exc_dec;
      @(negedge clk);
      clear_inputs();
    end
    while (cyc < m + 8) @(negedge clk);
  endtask

  initial begin
    int k, m;
    reset = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    reset = 1'b0;

    instr(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);   // sequential
    instr(3'd1, 1'b1, 1'b1, 1'b0, 1'b0);   // beq taken
    instr(3'd1, 1'b0, 1'b1, 1'b0, 1'b0);   // beq not taken
    instr(3'd2, 1'b0, 1'b1, 1'b0, 1'b0);   // bne taken
    instr(3'd2, 1'b1, 1'b1, 1'b0, 1'b0);   // bne not taken
    instr(3'd3, 1'b0, 1'b1, 1'b0, 1'b0);   // jump
    instr(3'd4, 1'b1, 1'b1, 1'b0, 1'b0);   // jr
    instr(3'd5, 1'b0, 1'b1, 1'b0, 1'b0);   // rte
    instr(3'd3, 1'b0, 1'b1, 1'b1, 1'b0);   // exception beats jump
    instr(3'd6, 1'b0, 1'b1, 1'b0, 1'b0);   // illegal kind 6
    instr(3'd7, 1'b1, 1'b1, 1'b0, 1'b0);   // illegal kind 7
    instr(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);   // exception pended in FETCH

    // Asynchronous reset while both instances sit in EXC_SAVE.
    @(negedge clk);
    fetch_req = 1'b1;
    k = cyc + 1;
    m = k + 6;
    for (int i = 0; i < 2; i++) begin
      push_w(i, k + fw(i), 3'b000);
      push(i, m, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    end
    @(negedge clk);
    fetch_req = 1'b0;
    while (cyc < m - 1) @(negedge clk);
    exc_req = 1'b1; redirect_valid = 1'b1; redirect_kind = 3'd3;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_zero("async_reset");
    clear_inputs();
    repeat (3) @(negedge clk);
    chk_zero("held_reset");
    reset = 1'b0;

    instr(3'd3, 1'b0, 1'b1, 1'b0, 1'b0);   // fresh instruction after reset

    // fetch_req and exc_req held high: back-to-back exception instructions,
    // one per IDLE visit.
    @(negedge clk);
    fetch_req = 1'b1; exc_req = 1'b1;
    k = cyc + 1;
    push_w(0, k + 1, 3'b000);  push_exc(0, k + 2);
    q0.pop_back();             // no busy fall between back-to-back instructions
    push_w(0, k + 7, 3'b000);  push_exc(0, k + 8);
    push_w(1, k + 4, 3'b000);  push_exc(1, k + 5);
    q1.pop_back();
    push_w(1, k + 13, 3'b000); push_exc(1, k + 14);
    while (cyc < k + 9) @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    exc_req = 1'b0;
    while (cyc < k + 22) @(negedge clk);

    n_cmp++;
    if (q0.size() != 0) begin
      n_bad++;
      $display("FAIL leftover inst0 got=%0d pending want=0", q0.size());
    end
    n_cmp++;
    if (q1.size() != 0) begin
      n_bad++;
      $display("FAIL leftover inst1 got=%0d pending want=0", q1.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
